// File: rtl/axi_read_slave_if.sv
// AXI read-address and read-data channel bundle between the interconnect and the SRAM read responder.
interface axi_read_slave_if #(
  parameter int IDS_W  = 8,
  parameter int DATA_W = 32
);
  logic [IDS_W-1:0]  ARID;
  logic [31:0]       ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [IDS_W-1:0]  RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_slave.sv
// AXI read responder in front of a 1-cycle-latency synchronous SRAM; one burst at a time,
// with a 2-entry output buffer so RREADY backpressure never stalls a full-rate stream.
module axi_read_slave #(
  parameter int IDS_W  = 8,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rstn,
  axi_read_slave_if.slave   axi,
  output logic              mem_cs,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_reg;
  logic                arready_reg;
  logic [IDS_W-1:0]    id_reg;
  logic [3:0]          len_reg;
  logic [1:0]          burst_reg;
  logic                err_reg;
  logic [4:0]          beats_left_reg;
  logic [MEM_AW-1:0]   addr_reg;
  logic                inflight_reg;
  logic                inflight_last_reg;

  logic                rd_ptr_reg;
  logic                wr_ptr_reg;
  logic [1:0]          count_reg;
  logic [1:0]          count_next;

  logic                ar_fire;
  logic                ar_err;
  logic                rvalid;
  logic                pop;
  logic [2:0]          occ_sum;
  logic                room;
  logic                issue;
  logic                issue_last;
  logic                err_push;
  logic                push;
  logic [DATA_W-1:0]   push_data;
  logic [1:0]          push_resp;
  logic                push_last;
  logic [DATA_W-1:0]   head_data;
  logic [1:0]          head_resp;
  logic                head_last;
  logic                burst_done;
  logic [MEM_AW-1:0]   wrap_mask;
  logic [MEM_AW-1:0]   addr_incr;
  logic [MEM_AW-1:0]   addr_next;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{axi.ARADDR[31:MEM_AW+2], axi.ARADDR[1:0]};

  assign ar_fire = axi.ARVALID & arready_reg;
  assign ar_err  = (axi.ARSIZE != 3'b010) ||
                   (axi.ARBURST == 2'b11) ||
                   ((axi.ARBURST == 2'b10) &&
                    !((axi.ARLEN == 4'd1) || (axi.ARLEN == 4'd3) ||
                      (axi.ARLEN == 4'd7) || (axi.ARLEN == 4'd15)));

  assign rvalid = (count_reg != 2'd0);
  assign pop    = rvalid & axi.RREADY;

  // Buffered plus in-flight beats, after this cycle's pop, must leave a free slot.
  assign occ_sum    = {1'b0, count_reg} + {2'b00, inflight_reg};
  assign room       = occ_sum < (3'd2 + {2'b00, pop});
  assign issue      = (state_reg == BURST) && (beats_left_reg != 5'd0) && room;
  assign issue_last = (beats_left_reg == 5'd1);

  assign mem_cs   = issue & ~err_reg;
  assign mem_addr = addr_reg;

  // Error bursts skip the SRAM and push their beat in the same cycle it is issued.
  assign err_push  = issue & err_reg;
  assign push      = inflight_reg | err_push;
  assign push_data = err_push ? '0 : mem_dout;
  assign push_resp = err_push ? 2'b10 : 2'b00;
  assign push_last = err_push ? issue_last : inflight_last_reg;

  // WRAP lengths are 2,4,8,16 beats, so ARLEN itself is the mask of the wrapping bits.
  assign wrap_mask = {{(MEM_AW-4){1'b0}}, len_reg};
  assign addr_incr = addr_reg + 1'b1;

  always_comb begin
    addr_next = addr_incr;
    case (burst_reg)
      2'b00:   addr_next = addr_reg;
      2'b10:   addr_next = (addr_reg & ~wrap_mask) | (addr_incr & wrap_mask);
      default: addr_next = addr_incr;
    endcase
  end

  assign burst_done = pop & head_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg         <= IDLE;
      arready_reg       <= 1'b0;
      id_reg            <= '0;
      len_reg           <= '0;
      burst_reg         <= '0;
      err_reg           <= 1'b0;
      beats_left_reg    <= '0;
      addr_reg          <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= mem_cs;
      inflight_last_reg <= issue_last;
      case (state_reg)
        IDLE: begin
          arready_reg <= 1'b1;
          if (ar_fire) begin
            state_reg      <= BURST;
            arready_reg    <= 1'b0;
            id_reg         <= axi.ARID;
            len_reg        <= axi.ARLEN;
            burst_reg      <= axi.ARBURST;
            err_reg        <= ar_err;
            beats_left_reg <= {1'b0, axi.ARLEN} + 5'd1;
            addr_reg       <= axi.ARADDR[MEM_AW+1:2];
          end
        end
        BURST: begin
          if (issue) begin
            beats_left_reg <= beats_left_reg - 5'd1;
            if (!err_reg) begin
              addr_reg <= addr_next;
            end
          end
          if (burst_done) begin
            state_reg   <= IDLE;
            arready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (!push && pop) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      logic [DATA_W-1:0] data_reg;
      logic [1:0]        resp_reg;
      logic              last_reg;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          data_reg <= '0;
          resp_reg <= 2'b00;
          last_reg <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= push_data;
          resp_reg <= push_resp;
          last_reg <= push_last;
        end
      end
    end
  endgenerate

  assign head_data = rd_ptr_reg ? g_buf[1].data_reg : g_buf[0].data_reg;
  assign head_resp = rd_ptr_reg ? g_buf[1].resp_reg : g_buf[0].resp_reg;
  assign head_last = rd_ptr_reg ? g_buf[1].last_reg : g_buf[0].last_reg;

  assign axi.ARREADY = arready_reg;
  assign axi.RVALID  = rvalid;
  assign axi.RID     = id_reg;
  assign axi.RDATA   = head_data;
  assign axi.RRESP   = head_resp;
  assign axi.RLAST   = head_last;

endmodule

// File: tb/tb_axi_read_slave.sv
// Randomized bench for axi_read_slave: SRAM model, bus monitor, and a burst-level reference model.
`timescale 1ns/1ps
module tb_axi_read_slave;
  localparam int IDS_W     = 8;
  localparam int DATA_W    = 32;
  localparam int MEM_AW    = 14;
  localparam int MEM_WORDS = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              mem_cs;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;

  axi_read_slave_if #(.IDS_W(IDS_W), .DATA_W(DATA_W)) axi ();

  axi_read_slave #(.IDS_W(IDS_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .axi      (axi),
    .mem_cs   (mem_cs),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] sram [MEM_WORDS];
  always @(posedge clk) if (mem_cs) mem_dout <= sram[mem_addr];

  typedef struct {
    logic [IDS_W-1:0]  id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    int                cyc;
  } beat_t;

  beat_t beat_q[$];
  int    addr_q[$];
  int    addr_cyc_q[$];
  int    ar_cyc_q[$];
  int    cyc = 0;
  int    stall_viol = 0;
  int    max_out = 0;
  int    out_cnt = 0;
  bit    prev_stall = 0;
  beat_t prev_b;

  int n_cmp = 0;
  int n_fail = 0;

  logic [IDS_W-1:0] req_id;
  logic [31:0]      req_addr;
  logic [3:0]       req_len;
  logic [2:0]       req_size;
  logic [1:0]       req_burst;
  bit               req_err;
  int               ar_base, beat_base, addr_base, rr_step;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: logs AR handshakes, SRAM reads and R beats; tracks stall stability and occupancy.
  always @(negedge clk) begin
    if (!rstn) begin
      out_cnt    = 0;
      prev_stall = 0;
    end else begin
      if (axi.ARVALID && axi.ARREADY) ar_cyc_q.push_back(cyc);
      if (mem_cs) begin
        addr_q.push_back(int'(mem_addr));
        addr_cyc_q.push_back(cyc);
      end
      if (prev_stall && (!axi.RVALID || axi.RID !== prev_b.id || axi.RDATA !== prev_b.data ||
                         axi.RRESP !== prev_b.resp || axi.RLAST !== prev_b.last))
        stall_viol++;
      if (axi.RVALID && axi.RREADY)
        beat_q.push_back('{axi.RID, axi.RDATA, axi.RRESP, axi.RLAST, cyc});
      out_cnt = out_cnt + (mem_cs ? 1 : 0) -
                ((axi.RVALID && axi.RREADY && axi.RRESP == 2'b00) ? 1 : 0);
      if (out_cnt > max_out) max_out = out_cnt;
      prev_stall = axi.RVALID && !axi.RREADY;
      prev_b = '{axi.RID, axi.RDATA, axi.RRESP, axi.RLAST, cyc};
    end
  end

  // Reference model
  function automatic bit is_err(input logic [2:0] size, input logic [1:0] burst, input logic [3:0] len);
    return (size != 3'b010) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  function automatic int exp_addr(input int i);
    int start, n, r;
    start = int'(req_addr[MEM_AW+1:2]);
    n = int'(req_len) + 1;
    case (req_burst)
      2'b00:   r = start;
      2'b10:   r = (start - start % n) + ((start % n) + i) % n;
      default: r = (start + i) % MEM_WORDS;
    endcase
    return r;
  endfunction

  function automatic beat_t exp_beat(input int i);
    beat_t e;
    e.id   = req_id;
    e.last = (i == int'(req_len));
    e.data = req_err ? '0 : sram[exp_addr(i)];
    e.resp = req_err ? 2'b10 : 2'b00;
    e.cyc  = 0;
    return e;
  endfunction

  function automatic logic rr_val(input int mode, input int step);
    logic [5:0] pat;
    pat = 6'b101001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return pat[step % 6];
  endfunction

  // Stimulus only: issues one AR, then drives RREADY until all beats have been handed over.
  task automatic run_burst(input logic [IDS_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    int guard;
    bit got;
    req_id = id; req_addr = addr; req_len = len; req_size = size; req_burst = burst;
    req_err   = is_err(size, burst, len);
    ar_base   = ar_cyc_q.size();
    beat_base = beat_q.size();
    addr_base = addr_q.size();
    rr_step   = 0;
    axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len; axi.ARSIZE = size; axi.ARBURST = burst;
    axi.ARVALID = 1'b1;
    got = 0; guard = 0;
    while (!got && guard < 50) begin
      @(negedge clk);
      got = axi.ARREADY;
      @(posedge clk); #1;
      guard++;
    end
    axi.ARVALID = 1'b0;
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL ar_handshake: got no ARREADY in %0d cycles, required handshake", guard);
    end
    guard = 0;
    while (beat_q.size() < beat_base + int'(len) + 1 && guard < 400) begin
      axi.RREADY = rr_val(mode, rr_step);
      rr_step++;
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (beat_q.size() < beat_base + int'(len) + 1) begin
      n_fail++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", beat_q.size() - beat_base, int'(len) + 1);
    end
    axi.RREADY = 1'b1;
    $display("burst id=%h addr=%h len=%0d size=%0d burst=%0d err=%0b beats=%0d",
             id, addr, len, size, burst, req_err, beat_q.size() - beat_base);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({axi.ARREADY, axi.RVALID, axi.RLAST, axi.RID, axi.RDATA, axi.RRESP, mem_cs, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=%b cs=%b addr=%h, required all 0",
               axi.ARREADY, axi.RVALID, axi.RLAST, axi.RID, axi.RDATA, axi.RRESP, mem_cs, mem_addr);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (axi.ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_arready: got %b, required 1", axi.ARREADY);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_incr_basic();
    int a0;
    beat_t g;
    run_burst(8'h25, 32'h10, 4'd3, 3'b010, 2'b01, 0);
    a0 = ar_cyc_q[ar_base];
    n_cmp++;
    if (addr_q.size() - addr_base !== 4) begin
      n_fail++;
      $display("FAIL incr_addr_count: got %0d, required 4", addr_q.size() - addr_base);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (addr_q[addr_base+i] !== 4 + i || addr_cyc_q[addr_base+i] !== a0 + 1 + i) begin
        n_fail++;
        $display("FAIL incr_addr[%0d]: got addr=%0d cyc=%0d, required addr=%0d cyc=%0d",
                 i, addr_q[addr_base+i], addr_cyc_q[addr_base+i], 4 + i, a0 + 1 + i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      g = beat_q[beat_base+i];
      n_cmp++;
      if ({g.id, g.data, g.resp, g.last} !== {8'h25, sram[4+i], 2'b00, (i == 3)} || g.cyc !== a0 + 3 + i) begin
        n_fail++;
        $display("FAIL incr_beat[%0d]: got id=%h data=%h resp=%b last=%b cyc=%0d, required id=25 data=%h resp=00 last=%b cyc=%0d",
                 i, g.id, g.data, g.resp, g.last, g.cyc, sram[4+i], (i == 3), a0 + 3 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    int sv0;
    beat_t g, e;
    sv0 = stall_viol;
    run_burst(8'($urandom), $urandom, 4'd15, 3'b010, 2'b01, 2);
    for (int i = 0; i < 16; i++) begin
      g = beat_q[beat_base+i];
      e = exp_beat(i);
      n_cmp++;
      if ({g.id, g.data, g.resp, g.last} !== {e.id, e.data, e.resp, e.last}) begin
        n_fail++;
        $display("FAIL bp_beat[%0d]: got id=%h data=%h resp=%b last=%b, required id=%h data=%h resp=%b last=%b",
                 i, g.id, g.data, g.resp, g.last, e.id, e.data, e.resp, e.last);
      end
    end
    n_cmp++;
    if (stall_viol !== sv0) begin
      n_fail++;
      $display("FAIL bp_stall_stable: got %0d unstable stall cycles, required 0", stall_viol - sv0);
    end
    n_cmp++;
    if (max_out > 2) begin
      n_fail++;
      $display("FAIL bp_outstanding: got max %0d reads outstanding+buffered, required <= 2", max_out);
    end
  endtask

  task automatic test_wrap_fixed();
    int wrap_exp[4];
    wrap_exp = '{6, 7, 4, 5};
    run_burst(8'h31, 32'h18, 4'd3, 3'b010, 2'b10, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (addr_q[addr_base+i] !== wrap_exp[i] || beat_q[beat_base+i].data !== sram[wrap_exp[i]]) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got addr=%0d data=%h, required addr=%0d data=%h",
                 i, addr_q[addr_base+i], beat_q[beat_base+i].data, wrap_exp[i], sram[wrap_exp[i]]);
      end
    end
    run_burst(8'h32, 32'h40, 4'd2, 3'b010, 2'b00, 1);
    n_cmp++;
    if (addr_q.size() - addr_base !== 3) begin
      n_fail++;
      $display("FAIL fixed_count: got %0d reads, required 3", addr_q.size() - addr_base);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (addr_q[addr_base+i] !== 16 || beat_q[beat_base+i].data !== sram[16] || beat_q[beat_base+i].last !== (i == 2)) begin
        n_fail++;
        $display("FAIL fixed[%0d]: got addr=%0d data=%h last=%b, required addr=16 data=%h last=%b",
                 i, addr_q[addr_base+i], beat_q[beat_base+i].data, beat_q[beat_base+i].last, sram[16], (i == 2));
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0] sz[3];
    logic [1:0] bu[3];
    logic [3:0] ln[3];
    sz = '{3'b011, 3'b010, 3'b010};
    bu = '{2'b01, 2'b10, 2'b11};
    ln = '{4'd1, 4'd2, 4'd0};
    for (int t = 0; t < 3; t++) begin
      run_burst(8'($urandom), $urandom, ln[t], sz[t], bu[t], 1);
      n_cmp++;
      if (addr_q.size() !== addr_base) begin
        n_fail++;
        $display("FAIL err%0d_mem_cs: got %0d SRAM reads, required 0", t, addr_q.size() - addr_base);
      end
      for (int i = 0; i <= int'(ln[t]); i++) begin
        n_cmp++;
        if ({beat_q[beat_base+i].id, beat_q[beat_base+i].data, beat_q[beat_base+i].resp, beat_q[beat_base+i].last}
            !== {req_id, 32'h0, 2'b10, (i == int'(ln[t]))}) begin
          n_fail++;
          $display("FAIL err%0d_beat[%0d]: got id=%h data=%h resp=%b last=%b, required id=%h data=0 resp=10 last=%b",
                   t, i, beat_q[beat_base+i].id, beat_q[beat_base+i].data, beat_q[beat_base+i].resp,
                   beat_q[beat_base+i].last, req_id, (i == int'(ln[t])));
        end
      end
      @(negedge clk);
      n_cmp++;
      if (axi.ARREADY !== 1'b1) begin
        n_fail++;
        $display("FAIL err%0d_idle: got ARREADY=%b, required 1", t, axi.ARREADY);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wraparound_b2b();
    int ar0, b0, guard, a_start, b_start;
    run_burst(8'h3C, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01, 0);
    n_cmp++;
    if (addr_q[addr_base] !== 16'h3FFF || addr_q[addr_base+1] !== 0) begin
      n_fail++;
      $display("FAIL incr_wraparound: got %h,%h, required 3fff,0000", addr_q[addr_base], addr_q[addr_base+1]);
    end
    n_cmp++;
    if (beat_q[beat_base].data !== sram[MEM_WORDS-1] || beat_q[beat_base+1].data !== sram[0]) begin
      n_fail++;
      $display("FAIL incr_wraparound_data: got %h,%h, required %h,%h",
               beat_q[beat_base].data, beat_q[beat_base+1].data, sram[MEM_WORDS-1], sram[0]);
    end
    // Back-to-back: ARVALID stays high; the second request only appears once the first is captured.
    ar0 = ar_cyc_q.size(); b0 = beat_q.size();
    a_start = $urandom_range(0, MEM_WORDS - 1);
    b_start = $urandom_range(0, MEM_WORDS - 1);
    axi.ARID = 8'h11; axi.ARADDR = 32'(a_start * 4); axi.ARLEN = 4'd2; axi.ARSIZE = 3'b010; axi.ARBURST = 2'b01;
    axi.ARVALID = 1'b1;
    guard = 0;
    while (ar_cyc_q.size() < ar0 + 1 && guard < 50) begin @(posedge clk); #1; guard++; end
    axi.ARID = 8'h22; axi.ARADDR = 32'(b_start * 4); axi.ARLEN = 4'd1;
    guard = 0;
    while (ar_cyc_q.size() < ar0 + 2 && guard < 100) begin @(posedge clk); #1; guard++; end
    axi.ARVALID = 1'b0;
    guard = 0;
    while (beat_q.size() < b0 + 5 && guard < 100) begin @(posedge clk); #1; guard++; end
    $display("burst b2b first_ar=%0d second_ar=%0d beats=%0d", ar_cyc_q[ar0], ar_cyc_q[ar0+1], beat_q.size() - b0);
    n_cmp++;
    if (ar_cyc_q.size() !== ar0 + 2 || ar_cyc_q[ar0+1] !== beat_q[b0+2].cyc + 1) begin
      n_fail++;
      $display("FAIL b2b_ar_timing: got %0d handshakes, second at cyc %0d, required 2 with second at cyc %0d",
               ar_cyc_q.size() - ar0, ar_cyc_q[ar0+1], beat_q[b0+2].cyc + 1);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i < 3 ? ({beat_q[b0+i].id, beat_q[b0+i].data, beat_q[b0+i].last} !==
                   {8'h11, sram[(a_start+i)%MEM_WORDS], (i == 2)})
                : ({beat_q[b0+i].id, beat_q[b0+i].data, beat_q[b0+i].last} !==
                   {8'h22, sram[(b_start+i-3)%MEM_WORDS], (i == 4)})) begin
        n_fail++;
        $display("FAIL b2b_beat[%0d]: got id=%h data=%h last=%b", i, beat_q[b0+i].id, beat_q[b0+i].data, beat_q[b0+i].last);
      end
    end
  endtask

  task automatic test_reset_midburst();
    int guard, nb, na;
    axi.ARID = 8'h5A; axi.ARADDR = $urandom; axi.ARLEN = 4'd7; axi.ARSIZE = 3'b010; axi.ARBURST = 2'b01;
    axi.ARVALID = 1'b1;
    nb = beat_q.size();
    guard = 0;
    while (ar_cyc_q.size() == ar_base + 0 && guard < 0) guard++;
    guard = 0; na = ar_cyc_q.size();
    while (ar_cyc_q.size() == na && guard < 50) begin @(posedge clk); #1; guard++; end
    axi.ARVALID = 1'b0;
    guard = 0;
    while (beat_q.size() < nb + 2 && guard < 50) begin @(posedge clk); #1; guard++; end
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({axi.RVALID, mem_cs, axi.ARREADY, axi.RLAST, axi.RDATA} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rvalid=%b cs=%b arready=%b rlast=%b rdata=%h, required all 0",
               axi.RVALID, mem_cs, axi.ARREADY, axi.RLAST, axi.RDATA);
    end
    nb = beat_q.size(); na = addr_q.size();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (axi.ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_arready: got %b, required 1", axi.ARREADY);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (beat_q.size() !== nb || addr_q.size() !== na) begin
      n_fail++;
      $display("FAIL midreset_stale: got %0d beats %0d reads after reset, required 0 0",
               beat_q.size() - nb, addr_q.size() - na);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [3:0] wl[4];
    beat_t g, e;
    wl = '{4'd1, 4'd3, 4'd7, 4'd15};
    for (int t = 0; t < 25; t++) begin
      len   = 4'($urandom_range(0, 15));
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
      burst = 2'($urandom_range(0, 3));
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = wl[$urandom_range(0, 3)];
      run_burst(8'($urandom), $urandom, len, size, burst, 1);
      n_cmp++;
      if (addr_q.size() - addr_base !== (req_err ? 0 : int'(len) + 1)) begin
        n_fail++;
        $display("FAIL rnd%0d_reads: got %0d, required %0d", t, addr_q.size() - addr_base, req_err ? 0 : int'(len) + 1);
      end
      for (int i = 0; i <= int'(len); i++) begin
        g = beat_q[beat_base+i];
        e = exp_beat(i);
        n_cmp++;
        if ({g.id, g.data, g.resp, g.last} !== {e.id, e.data, e.resp, e.last} ||
            (!req_err && addr_q[addr_base+i] !== exp_addr(i))) begin
          n_fail++;
          $display("FAIL rnd%0d_beat[%0d]: got id=%h data=%h resp=%b last=%b addr=%0d, required id=%h data=%h resp=%b last=%b addr=%0d",
                   t, i, g.id, g.data, g.resp, g.last, addr_q[addr_base+i], e.id, e.data, e.resp, e.last, exp_addr(i));
        end
      end
    end
    n_cmp++;
    if (stall_viol !== 0 || max_out > 2) begin
      n_fail++;
      $display("FAIL rnd_flow: got %0d unstable stalls, max outstanding %0d, required 0 and <= 2", stall_viol, max_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) sram[i] = $urandom;
    axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = 3'b010; axi.ARBURST = 2'b01;
    axi.ARVALID = 1'b0; axi.RREADY = 1'b1;
    test_reset();
    test_incr_basic();
    test_backpressure();
    test_wrap_fixed();
    test_errors();
    test_wraparound_b2b();
    test_reset_midburst();
    test_incr_basic();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
Name: axi_read_slave

Overview:
AXI read-channel responder that sits at the slave end of the interconnect, in front of a single-port synchronous SRAM with 1-cycle read latency.
- Accepts one AR request at a time and issues SRAM word reads.
- Returns RID/RDATA/RRESP/RLAST/RVALID bursts into the interconnect R-channel mux.
- Sustains one beat per cycle under RREADY backpressure via a 2-entry output buffer.

Parameters:
IDS_W, 8, width of ARID/RID (slave-side ID incl. master tag)
DATA_W, 32, data width; only word transfers supported
MEM_AW, 14, SRAM word-address width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
ARID  in  IDS_W  request ID
ARADDR  in  32  byte address
ARLEN  in  4  beats minus 1
ARSIZE  in  3  transfer size
ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
ARVALID  in  1  request valid
ARREADY  out  1  request accepted
RID  out  IDS_W  response ID
RDATA  out  DATA_W  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RLAST  out  1  final beat
RVALID  out  1  beat valid
RREADY  in  1  beat accepted
mem_cs  out  1  SRAM read strobe
mem_addr  out  MEM_AW  SRAM word address
mem_dout  in  DATA_W  SRAM data, valid the cycle after mem_cs

Behaviour:
- Reset: sampled on clk rising edge while rstn=0; applies mid-burst as well.
  - All state and buffers clear; in-flight data is discarded.
  - Outputs: ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=00, mem_cs=0, mem_addr=0.
  - ARREADY=1 from the first cycle after rstn returns to 1.
- States: IDLE, BURST.
  - ARREADY=1 only in IDLE. ARREADY does not depend combinationally on ARVALID.
- AR handshake: ARVALID&ARREADY at edge E0 captures ARID, ARLEN, ARBURST, start word = ARADDR[MEM_AW+1:2], and the error flag. State goes to BURST.
- Error flag is set if any of:
  - ARSIZE != 3'b010
  - ARBURST == 11
  - ARBURST == WRAP with ARLEN not in {1,3,7,15}
- Issue logic (BURST, no error): mem_cs=1 when beats left to issue > 0 and (buffer occupancy + reads in flight − pop this cycle) < 2.
  - Each issued read pushes mem_dout into the buffer one cycle later, tagged with its RLAST.
- Address sequence:
  - INCR: +1 word per beat, modulo 2^MEM_AW.
  - FIXED: constant.
  - WRAP: the low log2(ARLEN+1) bits increment and wrap; the upper bits are held.
- Latency: first mem_cs in cycle after E0; first RVALID=1 three cycles after the AR handshake cycle. With RREADY held at 1, one beat per cycle after that, no bubbles.
- Error burst: no SRAM access (mem_cs stays 0). ARLEN+1 beats are pushed at up to one per cycle with RDATA=0, RRESP=10, RLAST on the final beat.
- Normal burst: RRESP=00 on every beat.
- R channel:
  - RVALID = buffer not empty. RID/RDATA/RRESP/RLAST come from the head entry.
  - Once RVALID=1, these outputs hold stable until RVALID&RREADY.
  - RREADY=0 for any duration loses no data and never overflows the buffer.
- Burst completion: the handshake of the RLAST beat returns the state to IDLE. ARREADY=1 on the next cycle, so there is 1 idle cycle minimum between bursts.
- ARVALID while in BURST is ignored; the request is not captured.
- Simultaneous push and pop on a full buffer is legal; occupancy stays unchanged.

Test Plan:
- Reset mid-burst: rstn=0 on beat 2 of an ARLEN=7 burst -> next cycle RVALID=0, mem_cs=0, ARREADY=0; then ARREADY=1 one cycle after rstn=1; no stale beat appears.
- INCR, ARLEN=3, ARADDR=0x10, ARID=0x25, RREADY=1 -> mem_addr 4,5,6,7 on consecutive cycles; RVALID first at handshake+3; 4 back-to-back beats, RID=0x25, RLAST on beat 4 only, RRESP=00.
- RREADY toggled 1,0,0,1,0,1,... during ARLEN=15 INCR -> all 16 beats delivered in order with SRAM-matching data; outputs stable while stalled; never more than 2 reads outstanding+buffered.
- WRAP, ARLEN=3, ARADDR=0x18 (word 6) -> mem_addr 6,7,4,5; FIXED, ARLEN=2, ARADDR=0x40 -> mem_addr 16,16,16.
- Error cases -> ARSIZE=3'b011, ARLEN=1 gives 2 beats RRESP=10, RDATA=0, mem_cs never 1; WRAP with ARLEN=2 also gives SLVERR; both then return to IDLE.
- INCR wrap-around: ARADDR word 2^MEM_AW−1, ARLEN=1 -> mem_addr 0x3FFF then 0x0000; back-to-back ARVALID held high -> second AR accepted 1 cycle after first RLAST handshake.
